// File: rtl/block_scaling_scheduler.sv
// Ping-pong block buffer that finds a per-block exponent and streams
// a comma word followed by the left-normalised samples of each block.
module block_scaling_scheduler #(
    parameter int DATA_W    = 32,
    parameter int BLOCK_LEN = 16,
    parameter int SF_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inData,
    output logic              inReady,
    output logic              outValid,
    output logic              outComma,
    output logic [DATA_W-1:0] outData,
    output logic [SF_W-1:0]   scalingFactor
);
    localparam int IW = $clog2(BLOCK_LEN);
    localparam logic [IW-1:0] LAST = IW'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, COMMA, DATA} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [2*BLOCK_LEN];
    logic [3:0]        shift [2];
    logic [1:0]        full, full_nxt;
    logic              wr_bank, wr_bank_nxt, rd_bank;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic [14:0]       acc, acc_nxt;
    logic              accept, wr_last, rd_done;
    logic [3:0]        sh_new, rd_sh;
    logic [DATA_W-1:0] rd_word;

    function automatic logic [14:0] mag(input logic [15:0] x);
        logic [15:0] t;
        t = x ^ {16{x[15]}};
        return t[14:0];
    endfunction

    // Leading zeros of a 15-bit word; an all-zero word yields 15.
    function automatic logic [3:0] clz15(input logic [14:0] a);
        logic [3:0] n;
        logic       hit;
        n   = 4'd15;
        hit = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            if (!hit && a[i]) begin
                n   = 4'(14 - i);
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    assign accept  = inValid && inReady;
    assign acc_nxt = acc | mag(inData[31:16]) | mag(inData[15:0]);
    assign sh_new  = clz15(acc_nxt);
    assign wr_last = accept && (wr_idx == LAST);
    assign rd_sh   = shift[rd_bank];
    assign rd_word = mem[{rd_bank, rd_idx}];

    always_comb begin
        state_nxt = state;
        rd_done   = 1'b0;
        case (state)
            IDLE:  if (full[rd_bank]) state_nxt = COMMA;
            COMMA: state_nxt = DATA;
            DATA: begin
                if (rd_idx == LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = full[!rd_bank] ? COMMA : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt = wr_bank ^ wr_last;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_idx}] <= inData;
        if (wr_last) shift[wr_bank] <= sh_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            acc     <= '0;
            inReady <= 1'b1;
        end else begin
            state   <= state_nxt;
            full    <= full_nxt;
            wr_bank <= wr_bank_nxt;
            inReady <= !full_nxt[wr_bank_nxt];
            if (accept) begin
                wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
                acc    <= wr_last ? '0 : acc_nxt;
            end
            if (rd_done) begin
                rd_idx  <= '0;
                rd_bank <= !rd_bank;
            end else if (state == DATA) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid      <= 1'b0;
            outComma      <= 1'b0;
            outData       <= '0;
            scalingFactor <= '0;
        end else begin
            case (state)
                COMMA: begin
                    outValid      <= 1'b1;
                    outComma      <= 1'b1;
                    outData       <= {20'hBCBC0, {(DATA_W-24){1'b0}}, rd_sh};
                    scalingFactor <= SF_W'(rd_sh);
                end
                DATA: begin
                    outValid      <= 1'b1;
                    outComma      <= 1'b0;
                    outData       <= DATA_W'({rd_word[31:16] << rd_sh,
                                              rd_word[15:0] << rd_sh});
                    scalingFactor <= SF_W'(rd_sh);
                end
                default: begin
                    outValid <= 1'b0;
                    outComma <= 1'b0;
                    outData  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_block_scaling_scheduler.sv
// Randomised and directed bench for block_scaling_scheduler with a
// block-level reference model and a per-cycle output checker.
module tb_block_scaling_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        inReady;
    logic        outValid;
    logic        outComma;
    logic [31:0] outData;
    logic [11:0] scalingFactor;

    block_scaling_scheduler #(.DATA_W(32), .BLOCK_LEN(16), .SF_W(12)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inData(inData),
        .inReady(inReady), .outValid(outValid), .outComma(outComma),
        .outData(outData), .scalingFactor(scalingFactor)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_total = 0;
    int last_acc_cyc = 0;
    int pending = 0;
    int rem = 0;
    int data_seen = 0;
    int first_comma_cyc = -1;
    int last_word_cyc = 0;
    int ready_low = 0;
    bit chk_lat = 0;
    logic [3:0]  last_sf = '0;
    logic [31:0] cap_comma = '0;
    logic [31:0] cap_first = '0;
    logic [31:0] cap_last = '0;
    logic [11:0] cap_sf = '0;
    logic [36:0] expq[$];
    logic [31:0] blk[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: exponent = 15 - bit length of the largest magnitude.
    task automatic make_block();
        logic [14:0] orv;
        int len, m, s, iv, qv, pi, pq;
        logic [31:0] w;
        orv = '0;
        foreach (blk[k]) begin
            iv = $signed(blk[k][31:16]);
            qv = $signed(blk[k][15:0]);
            iv = (iv < 0) ? -iv - 1 : iv;
            qv = (qv < 0) ? -qv - 1 : qv;
            orv = orv | 15'(iv) | 15'(qv);
        end
        m = int'(orv);
        len = 0;
        while (m != 0) begin
            m = m >> 1;
            len++;
        end
        s = 15 - len;
        expq.push_back({1'b1, 4'(s), 20'hBCBC0, 8'h00, 4'(s)});
        foreach (blk[k]) begin
            iv = $signed(blk[k][31:16]);
            qv = $signed(blk[k][15:0]);
            pi = iv * (1 << s);
            pq = qv * (1 << s);
            w = {pi[15:0], pq[15:0]};
            expq.push_back({1'b0, 4'(s), w});
        end
    endtask

    always @(posedge clk) begin : mon
        logic r, a;
        logic [31:0] d;
        logic [36:0] e;
        r = rst;
        a = inValid && inReady && !rst;
        d = inData;
        cyc++;
        #1;
        if (r) begin
            expq.delete();
            blk.delete();
            pending = 0;
            rem = 0;
            last_sf = '0;
            check("rst_valid", 64'(outValid), 64'd0);
            check("rst_comma", 64'(outComma), 64'd0);
            check("rst_data", 64'(outData), 64'd0);
            check("rst_sf", 64'(scalingFactor), 64'd0);
            check("rst_ready", 64'(inReady), 64'd1);
        end else begin
            if (a) begin
                blk.push_back(d);
                acc_total++;
                last_acc_cyc = cyc;
                if (blk.size() == 16) begin
                    make_block();
                    pending++;
                    blk.delete();
                end
            end
            if (outValid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out actual=%0h required=none", outData);
                end else begin
                    e = expq.pop_front();
                    check("out_comma", 64'(outComma), 64'(e[36]));
                    check("out_data", 64'(outData), 64'(e[31:0]));
                    check("out_sf", 64'(scalingFactor), 64'(e[35:32]));
                    if (e[36]) begin
                        rem = 16;
                        data_seen = 0;
                        last_sf = e[35:32];
                        cap_comma = outData;
                        cap_sf = scalingFactor;
                        if (first_comma_cyc < 0) first_comma_cyc = cyc;
                        if (chk_lat) begin
                            check("latency", 64'(cyc - last_acc_cyc), 64'd2);
                            chk_lat = 0;
                        end
                    end else begin
                        rem--;
                        data_seen++;
                        if (data_seen == 1) cap_first = outData;
                        cap_last = outData;
                        last_word_cyc = cyc;
                        if (rem == 0) pending--;
                    end
                end
            end else begin
                check("gap", 64'(rem), 64'd0);
                check("idle_comma", 64'(outComma), 64'd0);
                check("idle_data", 64'(outData), 64'd0);
                check("idle_sf", 64'(scalingFactor), 64'(last_sf));
            end
            check("in_ready", 64'(inReady), 64'(pending < 2));
            if (!inReady) ready_low++;
        end
    end

    task automatic send(input logic [31:0] w);
        int n0;
        bit got;
        n0 = acc_total;
        got = 0;
        inValid = 1'b1;
        inData = w;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (acc_total > n0) begin
                got = 1;
                break;
            end
        end
        inValid = 1'b0;
        if (!got) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (expq.size() == 0 && rem == 0) begin
                ok = 1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    function automatic logic [15:0] rnd16();
        int s, bits;
        logic [15:0] m;
        s = $urandom_range(0, 15);
        bits = 15 - s;
        m = (bits == 0) ? 16'h0 : 16'($urandom & ((1 << bits) - 1));
        return ($urandom_range(0, 1) == 1) ? ~m : m;
    endfunction

    initial begin
        int base;
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t0_valid", 64'(outValid), 64'd0);
        check("t0_data", 64'(outData), 64'd0);
        check("t0_sf", 64'(scalingFactor), 64'd0);
        check("t0_ready", 64'(inReady), 64'd1);

        chk_lat = 1;
        for (int i = 0; i < 16; i++) send(32'h0100FF00);
        drain();
        check("t1_comma", 64'(cap_comma), 64'hBCBC0006);
        check("t1_sf", 64'(cap_sf), 64'h006);
        check("t1_first", 64'(cap_first), 64'h4000C000);
        check("t1_last", 64'(cap_last), 64'h4000C000);
        check("t1_lat_used", 64'(chk_lat), 64'd0);

        for (int i = 0; i < 16; i++) send(32'h00000000);
        drain();
        check("t2_comma", 64'(cap_comma), 64'hBCBC000F);
        check("t2_sf", 64'(cap_sf), 64'h00F);
        check("t2_first", 64'(cap_first), 64'h0);

        for (int i = 0; i < 15; i++) send(32'h00010001);
        send(32'h80000000);
        drain();
        check("t3_comma", 64'(cap_comma), 64'hBCBC0000);
        check("t3_first", 64'(cap_first), 64'h00010001);
        check("t3_last", 64'(cap_last), 64'h80000000);

        first_comma_cyc = -1;
        ready_low = 0;
        base = acc_total;
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            int k, b, j;
            k = acc_total - base;
            if (k >= 48) begin
                ok = 1;
                break;
            end
            b = k / 16;
            j = k % 16;
            inValid = 1'b1;
            inData = {16'(b * 256 + j * 3), 16'(-(j + 1) * (b + 1))};
            @(negedge clk);
        end
        inValid = 1'b0;
        check("t4_sent", 64'(ok), 64'd1);
        drain();
        check("t4_contig", 64'(last_word_cyc - first_comma_cyc), 64'd50);
        check("t4_ready_low", 64'(ready_low > 0), 64'd1);

        for (int i = 0; i < 16; i++) send({rnd16(), rnd16()});
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rem > 0 && data_seen == 5) begin
                ok = 1;
                break;
            end
        end
        check("t5_reached", 64'(ok), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_valid", 64'(outValid), 64'd0);
        for (int i = 0; i < 5; i++) send({rnd16(), rnd16()});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send(32'h0100FF00);
        drain();
        check("t5_comma", 64'(cap_comma), 64'hBCBC0006);
        check("t5_sf", 64'(cap_sf), 64'h006);
        check("t5_first", 64'(cap_first), 64'h4000C000);

        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send({rnd16(), rnd16()});
            end
        end
        drain();
        check("final_pending", 64'(pending), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
